// File: rtl/fsm_monitor_if.sv
// Monitor-side bundle for fsm_monitor: FSM observation inputs plus counter/flag/display outputs.
interface fsm_monitor_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               z;
    logic [2:0]         state;
    logic               z_rise;
    logic [COUNT_W-1:0] match_count;
    logic               illegal_seen;
    logic [6:0]         seg;
    logic [3:0]         an;

    // FSM side: drives z/state, observes monitor results
    modport master (
        output z, state,
        input  z_rise, match_count, illegal_seen, seg, an
    );

    modport slave (
        input  z, state,
        output z_rise, match_count, illegal_seen, seg, an
    );
endinterface

// File: rtl/fsm_monitor.sv
// Sequence-detector monitor: counts z rises, flags illegal states, scans a 4-digit 7-seg display.
// Optional macro FSM_MONITOR_SAT_EN: saturate match_count at all-ones instead of wrapping.
module fsm_monitor #(
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned MAX_STATE   = 4
) (
    input  logic          clk,
    input  logic          reset,
    fsm_monitor_if.slave  mon
);

    localparam int unsigned REF_W     = $clog2(REFRESH_DIV);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_E     = 7'b0000110;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t             digit_q, digit_next;
    logic [REF_W-1:0]   refresh_q, refresh_next;
    logic [COUNT_W-1:0] count_q, count_next;
    logic               z_prev_q;
    logic               illegal_q, illegal_next;
    logic [6:0]         seg_q, seg_next;
    logic [3:0]         an_q, an_next;
    logic               z_rise_c;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign z_rise_c         = mon.z & ~z_prev_q;
    assign mon.z_rise       = z_rise_c;
    assign mon.match_count  = count_q;
    assign mon.illegal_seen = illegal_q;
    assign mon.seg          = seg_q;
    assign mon.an           = an_q;

    // Next-state: digit scan, counter, sticky flag, and the display pair built from post-edge values
    always_comb begin
        digit_next   = digit_q;
        refresh_next = refresh_q + REF_W'(1);
        count_next   = count_q;
        illegal_next = illegal_q;
        seg_next     = SEG_BLANK;
        an_next      = 4'b1111;

        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_next = '0;
            case (digit_q)
                DIG0:    digit_next = DIG1;
                DIG1:    digit_next = DIG2;
                DIG2:    digit_next = DIG3;
                default: digit_next = DIG0;
            endcase
        end

`ifdef FSM_MONITOR_SAT_EN
        if (z_rise_c && !(&count_q)) begin
            count_next = count_q + COUNT_W'(1);
        end
`else
        if (z_rise_c) begin
            count_next = count_q + COUNT_W'(1);
        end
`endif

        if (32'(mon.state) > MAX_STATE) begin
            illegal_next = 1'b1;
        end

        // Display uses the same post-edge values that the registers will hold
        case (digit_next)
            DIG0: begin
                an_next  = 4'b1110;
                seg_next = hex_glyph(count_next[3:0]);
            end
            DIG1: begin
                an_next  = 4'b1101;
                seg_next = hex_glyph(count_next[7:4]);
            end
            DIG2: begin
                an_next  = 4'b1011;
                seg_next = SEG_BLANK;
            end
            default: begin
                an_next  = 4'b0111;
                seg_next = illegal_next ? SEG_E : hex_glyph({1'b0, mon.state});
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q   <= DIG0;
            refresh_q <= '0;
            count_q   <= '0;
            z_prev_q  <= 1'b0;
            illegal_q <= 1'b0;
            seg_q     <= SEG_ZERO;
            an_q      <= 4'b1110;
        end else begin
            digit_q   <= digit_next;
            refresh_q <= refresh_next;
            count_q   <= count_next;
            z_prev_q  <= mon.z;
            illegal_q <= illegal_next;
            seg_q     <= seg_next;
            an_q      <= an_next;
        end
    end

endmodule

// File: doc/fsm_monitor.md
Name: fsm_monitor

Overview:
- Downstream consumer of the binary sequence-detector FSM.
- Takes the FSM's z and 3-bit state outputs and counts detections (rising edges of z).
- Flags any unused/illegal state encoding.
- Drives a 4-digit multiplexed seven-segment display: detection count in hex on digits 1:0, current state on digit 3, digit 2 blank.

Parameters:
- COUNT_W, 8, width of detection counter; minimum 8.
- REFRESH_DIV, 100000, clk cycles per display digit slot; minimum 2.
- MAX_STATE, 4, highest legal state encoding; values above are illegal.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- z  input  1  FSM detection output.
- state  input  3  FSM current state encoding.
- z_rise  output  1  single-cycle pulse on z rising edge; combinational from z and z_prev.
- match_count  output  COUNT_W  registered detection count.
- illegal_seen  output  1  sticky illegal-state flag.
- seg  output  7  active-low segments; seg[0]=a … seg[6]=g.
- an  output  4  active-low digit enables, one-hot-low.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. Reset is sampled only on rising clk.
- Reset values:
  - z_prev=0, match_count=0, illegal_seen=0.
  - refresh counter=0, digit index=0.
  - an=4'b1110.
  - seg=pattern for hex 0 (count low nibble at reset).
- Edge detect:
  - z_prev <= z every cycle.
  - z_rise = z & ~z_prev.
  - A z held high for N cycles yields exactly one pulse.
  - z high in the first cycle after reset counts as a rise.
- Counter:
  - On an edge with z_rise=1, match_count <= match_count+1, visible the following cycle (1-cycle latency).
  - Default wrap: all-ones -> 0.
- Illegal detect:
  - On any edge where state > MAX_STATE, illegal_seen <= 1.
  - Cleared only by reset.
  - Counting continues regardless of illegal_seen.
- Display scan:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0->1->2->3->0.
  - an = one-hot-low of index: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
  - Digit sources:
    - idx0: match_count[3:0], hex glyph.
    - idx1: match_count[7:4], hex glyph.
    - idx2: blank, seg=7'h7F.
    - idx3: {1'b0,state} as hex glyph; if illegal_seen=1, glyph is "E" (7'b0000110) instead.
  - seg and an are registered together so they change on the same edge; no mismatched-digit cycle.
- Hex glyphs, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - z_rise and an illegal state on the same edge: both the increment and the flag set occur.
  - Counter wrap and display-slot advance on the same edge: the displayed value uses the post-edge count at its next registered update.
- Reset mid-operation: all state returns to reset values on that edge, overriding any pending increment; the display restarts at idx0.

Optional Feature:
- Macro: FSM_MONITOR_SAT_EN.
- Defined: match_count saturates at all-ones; further z rises leave it unchanged. Saturation also forces digits 1:0 to show "FF" (they already do for COUNT_W=8).
- Undefined: match_count wraps to 0 after all-ones.

Test Plan:
- Reset: hold reset 3 cycles, release, z=0, state=0 -> match_count=0, illegal_seen=0, z_rise=0, an=1110, seg=1000000.
- Edge counting: z high for 5 cycles, low 2, high 1 -> z_rise pulses exactly twice; match_count=2, updated 1 cycle after each rise.
- Wrap/saturate: drive 257 z rises with COUNT_W=8 -> without macro match_count=1; with FSM_MONITOR_SAT_EN match_count=255 (0xFF).
- Illegal state: state=3'b110 for 1 cycle, then state=2 -> illegal_seen=1 and stays 1; digit 3 glyph=0000110; reset clears it to 0.
- Display scan: REFRESH_DIV=4, match_count=0x3A, state=4 -> an sequence 1110,1101,1011,0111 each held 4 cycles; seg sequence 0001000, 0110000, 1111111, 0011001.
- Reset mid-count: match_count=7, assert reset on the same edge as a z rise -> match_count=0 next cycle, z_prev=0, an=1110.
